// File: rtl/mem_stage.sv
// Memory-access stage: retires ALU results and performs load/store over a
// req/ack handshake with a timeout guard, emitting one writeback record per instruction.
module mem_stage #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned RD_LSB  = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] aluresult,
  input  logic [15:0] instrin,
  input  logic [15:0] stdata,
  input  logic        isld,
  input  logic        isst,
  input  logic        iswb,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        out_valid,
  output logic [15:0] out_instr,
  output logic        wb_en,
  output logic [2:0]  wb_rd,
  output logic [15:0] wb_data,
  output logic        err
);

  typedef enum logic [0:0] {IDLE = 1'b0, MEM = 1'b1} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_wait, w_wait_nxt;
  logic [15:0] r_addr, w_addr_nxt;
  logic [15:0] r_wdata, w_wdata_nxt;
  logic [15:0] r_instr, w_instr_nxt;
  logic        r_we, w_we_nxt;
  logic        r_err, w_err_nxt;
  logic        r_out_valid, w_out_valid_nxt;
  logic [15:0] r_out_instr, w_out_instr_nxt;
  logic        r_wb_en, w_wb_en_nxt;
  logic [2:0]  r_wb_rd, w_wb_rd_nxt;
  logic [15:0] r_wb_data, w_wb_data_nxt;
  logic        w_accept;

  assign w_accept = in_valid && (r_state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wait      <= 8'd0;
      r_addr      <= 16'd0;
      r_wdata     <= 16'd0;
      r_instr     <= 16'd0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_instr <= 16'd0;
      r_wb_en     <= 1'b0;
      r_wb_rd     <= 3'd0;
      r_wb_data   <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait      <= w_wait_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_instr     <= w_instr_nxt;
      r_we        <= w_we_nxt;
      r_err       <= w_err_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_instr <= w_out_instr_nxt;
      r_wb_en     <= w_wb_en_nxt;
      r_wb_rd     <= w_wb_rd_nxt;
      r_wb_data   <= w_wb_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_wait_nxt      = r_wait;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_instr_nxt     = r_instr;
    w_we_nxt        = r_we;
    w_err_nxt       = r_err;
    w_out_valid_nxt = 1'b0;
    w_out_instr_nxt = r_out_instr;
    w_wb_en_nxt     = 1'b0;
    w_wb_rd_nxt     = r_wb_rd;
    w_wb_data_nxt   = r_wb_data;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (isld || isst) begin
            w_state_nxt = MEM;
            w_wait_nxt  = 8'd0;
            w_addr_nxt  = aluresult;
            w_wdata_nxt = stdata;
            w_instr_nxt = instrin;
            // Both flags set is illegal: it runs as a load and flags the error.
            w_we_nxt    = isst && !isld;
            if (isld && isst) begin
              w_err_nxt = 1'b1;
            end else begin
              w_err_nxt = r_err;
            end
          end else begin
            w_out_valid_nxt = 1'b1;
            w_out_instr_nxt = instrin;
            w_wb_en_nxt     = iswb;
            w_wb_rd_nxt     = instrin[RD_LSB +: 3];
            w_wb_data_nxt   = aluresult;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      MEM: begin
        // An ack on the final wait cycle takes precedence over the timeout.
        if (mem_ack) begin
          w_state_nxt     = IDLE;
          w_out_valid_nxt = 1'b1;
          w_out_instr_nxt = r_instr;
          w_wb_rd_nxt     = r_instr[RD_LSB +: 3];
          if (r_we) begin
            w_wb_en_nxt   = 1'b0;
            w_wb_data_nxt = 16'd0;
          end else begin
            w_wb_en_nxt   = 1'b1;
            w_wb_data_nxt = mem_rdata;
          end
        end else if (r_wait == TO_LAST) begin
          w_state_nxt     = IDLE;
          w_out_valid_nxt = 1'b1;
          w_out_instr_nxt = r_instr;
          w_wb_rd_nxt     = r_instr[RD_LSB +: 3];
          w_wb_en_nxt     = 1'b0;
          w_wb_data_nxt   = 16'd0;
          w_err_nxt       = 1'b1;
        end else begin
          w_wait_nxt = r_wait + 8'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign in_ready  = (r_state == IDLE);
  assign mem_req   = (r_state == MEM);
  assign mem_we    = (r_state == MEM) && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign wb_en     = r_wb_en;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage with hand-computed expectations (TIMEOUT=4).
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] aluresult;
  logic [15:0] instrin;
  logic [15:0] stdata;
  logic        isld, isst, iswb;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        out_valid;
  logic [15:0] out_instr;
  logic        wb_en;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        err;

  int n_vec  = 0;
  int n_miss = 0;
  int req_cycles;

  mem_stage #(.TIMEOUT(4), .RD_LSB(9)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .aluresult(aluresult), .instrin(instrin), .stdata(stdata),
    .isld(isld), .isst(isst), .iswb(iswb),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_instr(out_instr), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; aluresult = 16'h0000; instrin = 16'h0000;
    stdata = 16'h0000; isld = 1'b0; isst = 1'b0; iswb = 1'b0;
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    step(); step();
    check_vec("rst_in_ready", 16'(in_ready), 16'h0001);
    check_vec("rst_mem_req", 16'(mem_req), 16'h0000);
    check_vec("rst_mem_addr", mem_addr, 16'h0000);
    check_vec("rst_out_valid", 16'(out_valid), 16'h0000);
    check_vec("rst_err", 16'(err), 16'h0000);
    rst = 1'b0;

    // pending load interrupted by a two-cycle reset
    in_valid = 1'b1; isld = 1'b1; iswb = 1'b1; aluresult = 16'h0040; instrin = 16'h0200;
    step();
    in_valid = 1'b0; isld = 1'b0;
    check_vec("pend_mem_req", 16'(mem_req), 16'h0001);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check_vec("midrst_mem_req", 16'(mem_req), 16'h0000);
    check_vec("midrst_in_ready", 16'(in_ready), 16'h0001);
    check_vec("midrst_mem_we", 16'(mem_we), 16'h0000);
    check_vec("midrst_wb_data", wb_data, 16'h0000);
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    step();
    mem_ack = 1'b0;
    check_vec("late_ack_no_valid", 16'(out_valid), 16'h0000);

    // back-to-back non-memory
    in_valid = 1'b1; aluresult = 16'h0005; instrin = 16'h0600; iswb = 1'b1;
    step();
    check_vec("add_valid", 16'(out_valid), 16'h0001);
    check_vec("add_wb_en", 16'(wb_en), 16'h0001);
    check_vec("add_wb_rd", 16'(wb_rd), 16'h0003);
    check_vec("add_wb_data", wb_data, 16'h0005);
    check_vec("add_instr", out_instr, 16'h0600);
    aluresult = 16'h0007; instrin = 16'h0A00; iswb = 1'b0;
    step();
    in_valid = 1'b0;
    check_vec("cmp_valid", 16'(out_valid), 16'h0001);
    check_vec("cmp_wb_en", 16'(wb_en), 16'h0000);
    check_vec("cmp_instr", out_instr, 16'h0A00);
    step();
    check_vec("idle_valid", 16'(out_valid), 16'h0000);

    // load with three request cycles
    in_valid = 1'b1; isld = 1'b1; iswb = 1'b1; aluresult = 16'h0040; instrin = 16'h0200;
    step();
    in_valid = 1'b0; isld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_vec("ld_mem_req", 16'(mem_req), 16'h0001);
      check_vec("ld_mem_we", 16'(mem_we), 16'h0000);
      check_vec("ld_mem_addr", mem_addr, 16'h0040);
      check_vec("ld_in_ready", 16'(in_ready), 16'h0000);
      check_vec("ld_no_valid", 16'(out_valid), 16'h0000);
      if (i == 2) begin
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
      end
      step();
    end
    mem_ack = 1'b0;
    check_vec("ld_valid", 16'(out_valid), 16'h0001);
    check_vec("ld_wb_en", 16'(wb_en), 16'h0001);
    check_vec("ld_wb_rd", 16'(wb_rd), 16'h0001);
    check_vec("ld_wb_data", wb_data, 16'hBEEF);
    check_vec("ld_req_low", 16'(mem_req), 16'h0000);
    check_vec("ld_ready", 16'(in_ready), 16'h0001);

    // zero-wait store, then an accept on the retire edge
    in_valid = 1'b1; isst = 1'b1; iswb = 1'b0; aluresult = 16'h0010; stdata = 16'h1234;
    instrin = 16'h0400;
    step();
    in_valid = 1'b0; isst = 1'b0;
    check_vec("st_mem_req", 16'(mem_req), 16'h0001);
    check_vec("st_mem_we", 16'(mem_we), 16'h0001);
    check_vec("st_mem_addr", mem_addr, 16'h0010);
    check_vec("st_mem_wdata", mem_wdata, 16'h1234);
    mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    step();
    mem_ack = 1'b0;
    check_vec("st_valid", 16'(out_valid), 16'h0001);
    check_vec("st_wb_en", 16'(wb_en), 16'h0000);
    check_vec("st_wb_data", wb_data, 16'h0000);
    check_vec("st_ready", 16'(in_ready), 16'h0001);
    in_valid = 1'b1; iswb = 1'b1; aluresult = 16'h0077; instrin = 16'h0E00;
    step();
    in_valid = 1'b0;
    check_vec("post_st_valid", 16'(out_valid), 16'h0001);
    check_vec("post_st_rd", 16'(wb_rd), 16'h0007);
    check_vec("post_st_data", wb_data, 16'h0077);

    // timeout: never ack
    in_valid = 1'b1; isld = 1'b1; aluresult = 16'h0020; instrin = 16'h0200;
    step();
    in_valid = 1'b0; isld = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req) begin
        req_cycles++;
        step();
      end
    end
    check_vec("to_req_cycles", 16'(req_cycles), 16'h0004);
    step();
    step();
    check_vec("to_err_sticky", 16'(err), 16'h0001);
    // rerun to observe the retire cycle itself
    rst = 1'b1; step(); rst = 1'b0;
    check_vec("rst_clears_err", 16'(err), 16'h0000);
    in_valid = 1'b1; isld = 1'b1;
    step();
    in_valid = 1'b0; isld = 1'b0;
    step(); step(); step(); step();
    check_vec("to_valid", 16'(out_valid), 16'h0001);
    check_vec("to_wb_en", 16'(wb_en), 16'h0000);
    check_vec("to_err", 16'(err), 16'h0001);
    check_vec("to_req_low", 16'(mem_req), 16'h0000);
    rst = 1'b1; step(); rst = 1'b0;

    // ack on the timeout cycle wins
    in_valid = 1'b1; isld = 1'b1; aluresult = 16'h0050; instrin = 16'h0A00;
    step();
    in_valid = 1'b0; isld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        mem_ack = 1'b1; mem_rdata = 16'hCAFE;
      end
      step();
    end
    mem_ack = 1'b0;
    check_vec("co_valid", 16'(out_valid), 16'h0001);
    check_vec("co_wb_en", 16'(wb_en), 16'h0001);
    check_vec("co_wb_data", wb_data, 16'hCAFE);
    check_vec("co_err", 16'(err), 16'h0000);

    // isld and isst together: runs as a load, sets err
    in_valid = 1'b1; isld = 1'b1; isst = 1'b1; aluresult = 16'h0030; stdata = 16'h9999;
    step();
    in_valid = 1'b0; isld = 1'b0; isst = 1'b0;
    check_vec("ill_mem_req", 16'(mem_req), 16'h0001);
    check_vec("ill_mem_we", 16'(mem_we), 16'h0000);
    check_vec("ill_err", 16'(err), 16'h0001);
    mem_ack = 1'b1; mem_rdata = 16'h5A5A;
    step();
    check_vec("ill_valid", 16'(out_valid), 16'h0001);
    check_vec("ill_wb_en", 16'(wb_en), 16'h0001);
    check_vec("ill_wb_data", wb_data, 16'h5A5A);
    step();
    mem_ack = 1'b0;
    check_vec("idle_ack_ignored", 16'(out_valid), 16'h0000);
    check_vec("idle_ack_req", 16'(mem_req), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
